// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared types and default sizing for the multi-port register file.
//   rf_state_e   : clear-sequencer state (RF_CLEAR while zeroing, RF_READY after)
//   RF_DATA_W    : default register width
//   RF_DEPTH     : default number of registers
//   RF_NUM_RD/WR : default read / write port counts
// -----------------------------------------------------------------------------
package reg_file_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;
  localparam int RF_NUM_WR = 2;

endpackage

// File: rtl/reg_file_mp_if.sv
// -----------------------------------------------------------------------------
// reg_file_mp_if
// Bundle between operand-fetch/writeback (master) and the register file (slave).
//   rd_addr    : NUM_RD*AW     read addresses, port p at [p*AW +: AW]
//   rd_data    : NUM_RD*DATA_W combinational read data
//   wr_en      : NUM_WR        per-port write enable (higher index wins)
//   wr_addr    : NUM_WR*AW     write addresses
//   wr_data    : NUM_WR*DATA_W write data
//   rsv_en     : 1             reserve a destination register (scoreboard)
//   rsv_addr   : AW            register to reserve
//   rd_pending : NUM_RD        read operand has an outstanding reservation
//   ready      : 1             clear sequence finished, file usable
// -----------------------------------------------------------------------------
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = RF_NUM_RD,
  parameter int NUM_WR = RF_NUM_WR,
  parameter int AW     = $clog2(DEPTH)
);

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_pending, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_pending, ready
  );

endinterface

// File: rtl/reg_file_clear_seq.sv
// -----------------------------------------------------------------------------
// reg_file_clear_seq
// Walks every register once after reset, zeroing one entry per clock, then
// raises ready and stays there until the next reset.
//   clk        : clock
//   reset      : synchronous active-high reset (restarts the walk at entry 0)
//   o_clr_we   : zero-write strobe for the array (also high during reset,
//                which zeroes entry 0 on the reset edge)
//   o_clr_addr : entry being zeroed
//   o_ready    : walk complete
// -----------------------------------------------------------------------------
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr,
  output logic          o_ready
);

  rf_state_e     r_state;
  rf_state_e     w_state_nxt;
  logic [AW-1:0] r_clr_ptr;
  logic [AW-1:0] w_clr_ptr_nxt;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RF_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    o_clr_we      = 1'b0;
    o_clr_addr    = r_clr_ptr;
    o_ready       = 1'b0;

    unique case (r_state)
      RF_CLEAR: begin
        o_clr_we      = 1'b1;
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == AW'(DEPTH - 1)) w_state_nxt = RF_READY;
      end
      RF_READY: begin
        o_ready = 1'b1;
      end
      default: ;
    endcase

    // The reset edge itself zeroes entry 0 and suppresses everything else.
    if (reset) begin
      o_clr_we   = 1'b1;
      o_clr_addr = '0;
      o_ready    = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// Parametrised multi-port register file with write priority, same-cycle
// read bypass and a post-reset clear sequence.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : reg_file_mp_if.slave (read/write ports, reservation, ready)
// Parameters: DATA_W, DEPTH (power of two), NUM_RD, NUM_WR (higher index has
// priority), ZERO_REG (register 0 reads 0 and ignores writes).
// Optional build macro REG_FILE_MP_SCOREBOARD_EN adds a pending-write
// scoreboard; without it rd_pending is 0 and rsv_en/rsv_addr are ignored.
// -----------------------------------------------------------------------------
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic              w_clr_we;
  logic [AW-1:0]     w_clr_addr;
  logic              w_ready;
  logic [DATA_W-1:0] r_mem [DEPTH];

  reg_file_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_ready    (w_ready)
  );

  assign bus.ready = w_ready;

  // NOTE: the array has no reset branch; it is zeroed by the clear sequencer
  // one entry per cycle, which keeps it mappable to plain RAM/flop arrays.
  // Write ports are visited in ascending order so the highest index lands last.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_ready) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (ZERO_REG == 0 || bus.wr_addr[w*AW +: AW] != '0)) begin
          r_mem[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef REG_FILE_MP_SCOREBOARD_EN
  logic [DEPTH-1:0] r_pending;

  // Writes retire reservations; a reservation on the same edge is applied
  // afterwards so the newer reservation survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_ready) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w]) r_pending[bus.wr_addr[w*AW +: AW]] <= 1'b0;
      end
      if (bus.rsv_en && (ZERO_REG == 0 || bus.rsv_addr != '0)) begin
        r_pending[bus.rsv_addr] <= 1'b1;
      end
    end
  end
`else
  logic w_unused_rsv;
  assign w_unused_rsv = ^{bus.rsv_en, bus.rsv_addr};
`endif

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_word;

    assign w_addr = bus.rd_addr[p*AW +: AW];

    // Bypass: an in-flight write to the same address overrides the stored
    // value; later (higher-priority) ports overwrite earlier matches.
    always_comb begin
      w_word = r_mem[w_addr];
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == w_addr) begin
          w_word = bus.wr_data[w*DATA_W +: DATA_W];
        end
      end
    end

    assign bus.rd_data[p*DATA_W +: DATA_W] =
      (!w_ready || (ZERO_REG != 0 && w_addr == '0)) ? '0 : w_word;

`ifdef REG_FILE_MP_SCOREBOARD_EN
    logic w_hit;

    // A write landing this cycle satisfies the reservation already.
    always_comb begin
      w_hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == w_addr) w_hit = 1'b1;
      end
    end

    assign bus.rd_pending[p] = w_ready & r_pending[w_addr] & ~w_hit;
`else
    assign bus.rd_pending[p] = 1'b0;
`endif
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the CPU's 2-read/1-write register file.
- Adds configurable width, depth and read/write port counts.
- Adds multi-port write priority with same-cycle bypass, and a sequenced clear after reset (one entry per cycle) with a ready flag.
- Optionally adds a pending-write scoreboard for long-latency units.
- Sits between decode/operand-fetch and the writeback stage of the CPU pipeline.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, >= 2)
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports; a higher index has higher priority
- ZERO_REG, 1, when 1, register 0 reads as 0 and writes to it are dropped

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*AW  read addresses, port p at bits [p*AW +: AW]; AW = $clog2(DEPTH)
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- rsv_en  in  1  reserve destination register (scoreboard)
- rsv_addr  in  AW  register to reserve
- rd_pending  out  NUM_RD  read operand has an outstanding reservation
- ready  out  1  clear sequence complete; file is usable

Behaviour:
- Reset is one clock with synchronous, active-high reset.
- On any edge with reset=1:
  - state <= RF_CLEAR, clr_ptr <= 0, ready <= 0.
  - All pending bits <= 0.
  - Entry 0 is written 0.
- RF_CLEAR, reset=0:
  - Each edge writes 0 to entry clr_ptr, then clr_ptr <= clr_ptr+1.
  - On the edge that clears DEPTH-1: state <= RF_READY, ready <= 1.
  - ready therefore rises exactly DEPTH edges after reset deasserts.
- Reset asserted mid-clear restarts the sequence from entry 0.
- While ready=0:
  - wr_en and rsv_en are ignored.
  - rd_data is all zeros.
  - rd_pending is 0.
- Reads (ready=1), combinational, per port, in priority order:
  1. ZERO_REG=1 and addr==0 -> 0.
  2. Otherwise, any write port enabled to the same address -> that port's wr_data; the highest enabled index wins (bypass).
  3. Otherwise -> stored value.
- Writes (ready=1):
  - On an edge, each enabled port writes its entry.
  - Same address on several ports: the highest index lands.
  - ZERO_REG=1: writes to address 0 are discarded.
- Out-of-range addresses cannot occur (DEPTH is a power of two).
- RF_READY has no exit except reset.

Optional Feature:
- Macro: REG_FILE_MP_SCOREBOARD_EN
- Defined:
  - Keep a DEPTH-bit pending vector.
  - rsv_en sets pending[rsv_addr] on the edge.
  - Any wr_en to an address clears its bit.
  - Reserve and write to the same address on the same edge -> the bit is set (the new reservation wins).
  - rd_pending[p] = pending[rd_addr[p]] & ~(any wr_en to that address this cycle).
  - Address 0 is never pending when ZERO_REG=1.
- Undefined:
  - rd_pending is tied to 0 and rsv_en/rsv_addr are ignored.
  - Ports remain present.

Decomposition:
- Package reg_file_pkg holds:
  - typedef enum logic {RF_CLEAR, RF_READY} rf_state_e
  - default constants RF_DATA_W=32, RF_DEPTH=32
- Sub-module reg_file_clear_seq (FSM + clr_ptr) is natural.
  - Inputs: clk, reset.
  - Outputs: clr_we, clr_addr, ready.
- The top level holds the array, write-priority logic, bypass muxes and scoreboard.

Test Plan:
1. Reset 1 cycle, then hold idle. -> ready=0 for 32 edges, ready=1 on the 32nd. Before ready, reads of 0x5 return 0 and writes are ignored.
2. Write r7=0xDEADBEEF on port0 while reading r7 on rd0 in the same cycle. -> rd_data0=0xDEADBEEF (bypass). Next cycle, with no write, rd_data0 is still 0xDEADBEEF.
3. Port0 writes r3=0x11, port1 writes r3=0x22 on the same edge. -> Same-cycle read gives 0x22; later read gives 0x22. Then write r0=0xFF -> read r0=0.
4. After r9=0x1234 is written, assert reset on the 10th clear cycle of the sequence that follows. -> clr_ptr restarts at 0, ready rises 32 edges after that reset deasserts, and r9 reads 0.
5. With SCOREBOARD_EN: reserve r5 -> rd_pending=1 on the following cycles. Writing r5=0x77 -> same-cycle pending=0 with data 0x77. Reserve and write r5 on the same edge -> pending=1 afterwards.
6. Without SCOREBOARD_EN: reserve r5 -> rd_pending stays 0.
